// File: rtl/multi_channel_counter.sv
// Wishbone-mapped bank of independent up/down counters with compare, sticky
// match/overflow status, one-shot stop and an aggregated interrupt.
module multi_channel_counter #(
    parameter int unsigned BITS     = 32,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [3:0]                 wstrb,
    input  logic [7:0]                 addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata,
    output logic                       ready,
    output logic [CHANNELS*BITS-1:0]   count,
    output logic                       irq
);

    localparam int unsigned CTRL_W  = 5;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CMP    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam logic [BITS-1:0] MAX_VAL = '1;

    // CTRL bit positions
    localparam int unsigned C_EN      = 0;
    localparam int unsigned C_DIR     = 1;
    localparam int unsigned C_SAT     = 2;
    localparam int unsigned C_IRQ_EN  = 3;
    localparam int unsigned C_ONESHOT = 4;

    logic                      accept;
    logic                      is_write;
    logic [3:0]                ch;
    logic [1:0]                rsel;
    logic                      ch_ok;
    logic [CHANNELS-1:0][31:0] ch_rd;
    logic [CHANNELS-1:0]       ch_irq;
    logic [31:0]               rd_sel;
    logic                      unused_addr;

    assign accept      = valid & ~ready;
    assign is_write    = |wstrb;
    assign ch          = addr[7:4];
    assign rsel        = addr[3:2];
    assign ch_ok       = (32'(ch) < CHANNELS);
    assign unused_addr = ^addr[1:0];

    // Byte-lane merge of write data into an existing 32-bit register image
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] d,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = d[b*8 +: 8];
            end
        end
        return res;
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CTRL_W-1:0] ctrl_q;
        logic [BITS-1:0]   cnt_q;
        logic [BITS-1:0]   cmp_q;
        logic              match_q;
        logic              ovf_q;

        logic              sel;
        logic              wr_ctrl;
        logic              wr_cnt;
        logic              wr_cmp;
        logic              wr_stat;
        logic              counting;
        logic              at_limit;
        logic [BITS-1:0]   step_val;
        logic              match_ev;
        logic              ovf_ev;

        assign sel      = accept & is_write & ch_ok & (ch == 4'(i));
        assign wr_ctrl  = sel & (rsel == REG_CTRL) & wstrb[0];
        assign wr_cnt   = sel & (rsel == REG_COUNT);
        assign wr_cmp   = sel & (rsel == REG_CMP);
        assign wr_stat  = sel & (rsel == REG_STATUS) & wstrb[0];

        // A bus COUNT write pre-empts counting for this cycle
        assign counting = ctrl_q[C_EN] & ~wr_cnt;

        // Next counted value with wrap/saturate at either end of the range
        always_comb begin
            at_limit = 1'b0;
            step_val = cnt_q;
            if (ctrl_q[C_DIR]) begin
                at_limit = (cnt_q == '0);
                if (at_limit) begin
                    step_val = ctrl_q[C_SAT] ? '0 : MAX_VAL;
                end else begin
                    step_val = cnt_q - BITS'(1);
                end
            end else begin
                at_limit = (cnt_q == MAX_VAL);
                if (at_limit) begin
                    step_val = ctrl_q[C_SAT] ? MAX_VAL : '0;
                end else begin
                    step_val = cnt_q + BITS'(1);
                end
            end
        end

        assign ovf_ev   = counting & at_limit;
        assign match_ev = counting & (step_val == cmp_q);

        // Channel registers; set events take priority over W1C
        always_ff @(posedge clk) begin
            if (reset) begin
                ctrl_q  <= '0;
                cnt_q   <= '0;
                cmp_q   <= '0;
                match_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                if (wr_ctrl) begin
                    ctrl_q <= wdata[CTRL_W-1:0];
                end else if (match_ev && ctrl_q[C_ONESHOT]) begin
                    ctrl_q[C_EN] <= 1'b0;
                end

                if (wr_cnt) begin
                    cnt_q <= BITS'(merge_bytes(32'(cnt_q), wdata, wstrb));
                end else if (counting) begin
                    cnt_q <= step_val;
                end

                if (wr_cmp) begin
                    cmp_q <= BITS'(merge_bytes(32'(cmp_q), wdata, wstrb));
                end

                match_q <= match_ev | (match_q & ~(wr_stat & wdata[0]));
                ovf_q   <= ovf_ev   | (ovf_q   & ~(wr_stat & wdata[1]));
            end
        end

        // Per-channel read image, zero-extended to the bus width
        always_comb begin
            ch_rd[i] = '0;
            case (rsel)
                REG_CTRL:   ch_rd[i] = 32'(ctrl_q);
                REG_COUNT:  ch_rd[i] = 32'(cnt_q);
                REG_CMP:    ch_rd[i] = 32'(cmp_q);
                REG_STATUS: ch_rd[i] = {30'd0, ovf_q, match_q};
                default:    ch_rd[i] = '0;
            endcase
        end

        assign ch_irq[i]             = match_q & ctrl_q[C_IRQ_EN];
        assign count[i*BITS +: BITS] = cnt_q;
    end

    // Select the addressed channel's read image; unmapped channels read 0
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == 4'(i)) begin
                rd_sel = ch_rd[i];
            end
        end
    end

    // Bus ack, read data capture and registered interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= '0;
            irq   <= 1'b0;
        end else begin
            ready <= accept;
            rdata <= (accept && !is_write) ? rd_sel : '0;
            irq   <= |ch_irq;
        end
    end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed bench for multi_channel_counter: a 32-bit and an 8-bit instance
// share one bus so each scenario can be checked at both widths.
module tb_multi_channel_counter;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid;
    logic [3:0]   wstrb;
    logic [7:0]   addr;
    logic [31:0]  wdata;

    logic [31:0]  rdata32, rdata8;
    logic         ready32, ready8;
    logic [127:0] count32;
    logic [31:0]  count8;
    logic         irq32, irq8;

    logic [127:0] snap32;
    logic         snap_irq8;
    logic [31:0]  r32, r8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_channel_counter #(.BITS(32), .CHANNELS(4)) dut32 (
        .clk(clk), .reset(reset), .valid(valid), .wstrb(wstrb), .addr(addr),
        .wdata(wdata), .rdata(rdata32), .ready(ready32), .count(count32), .irq(irq32)
    );

    multi_channel_counter #(.BITS(8), .CHANNELS(4)) dut8 (
        .clk(clk), .reset(reset), .valid(valid), .wstrb(wstrb), .addr(addr),
        .wdata(wdata), .rdata(rdata8), .ready(ready8), .count(count8), .irq(irq8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction: accept edge, ack check, then one idle edge
    task automatic xfer(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] o32, output logic [31:0] o8);
        valid = 1'b1; addr = a; wstrb = s; wdata = d;
        @(posedge clk); #1;
        check("ack", 32'(ready32), 32'd1);
        o32 = rdata32;
        o8  = rdata8;
        snap32    = count32;
        snap_irq8 = irq8;
        valid = 1'b0; wstrb = 4'd0;
        @(posedge clk); #1;
        check("ack_drop", 32'(ready32), 32'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] t32, t8;
        xfer(a, s, d, t32, t8);
    endtask

    task automatic rd(input logic [7:0] a);
        xfer(a, 4'd0, 32'd0, r32, r8);
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; wstrb = 4'd0; addr = 8'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready32), 32'd0);
        check("rst_rdata", rdata32, 32'd0);
        check("rst_count", 32'(|count32), 32'd0);
        check("rst_irq", 32'(irq32 | irq8), 32'd0);
        reset = 1'b0;

        // Read after reset
        rd(8'h04);
        check("ch0_count_rd", r32, 32'd0);

        // CH1 compare match and W1C
        wr(8'h18, 4'hF, 32'd5);
        wr(8'h14, 4'hF, 32'd0);
        wr(8'h10, 4'h1, 32'd1);
        check("ch1_cnt1", count32[63:32], 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("ch1_cnt5", count32[63:32], 32'd5);
        rd(8'h1C);
        check("ch1_match", r32, 32'h1);
        wr(8'h1C, 4'h1, 32'h1);
        rd(8'h1C);
        check("ch1_w1c", r32, 32'h0);
        wr(8'h10, 4'h1, 32'd0);

        // 8-bit up-wrap on CH0
        wr(8'h08, 4'hF, 32'h80);
        wr(8'h04, 4'hF, 32'hFE);
        wr(8'h00, 4'h1, 32'h1);
        check("wrap_ff", 32'(count8[7:0]), 32'hFF);
        @(posedge clk); #1;
        check("wrap_00", 32'(count8[7:0]), 32'h00);
        wr(8'h00, 4'h1, 32'h0);
        rd(8'h0C);
        check("wrap_ovf8", r8, 32'h2);
        check("nowrap_ovf32", r32, 32'h0);
        wr(8'h0C, 4'h1, 32'h3);

        // 8-bit down-saturate on CH0
        wr(8'h04, 4'hF, 32'h01);
        wr(8'h00, 4'h1, 32'h7);
        check("dsat_0", 32'(count8[7:0]), 32'h00);
        @(posedge clk); #1;
        check("dsat_hold", 32'(count8[7:0]), 32'h00);
        rd(8'h0C);
        check("dsat_ovf", r8, 32'h2);
        check("dsat_hold2", 32'(count8[7:0]), 32'h00);
        wr(8'h00, 4'h1, 32'h0);
        wr(8'h0C, 4'h1, 32'h3);

        // One-shot with interrupt on CH0
        wr(8'h08, 4'hF, 32'd3);
        wr(8'h04, 4'hF, 32'd0);
        wr(8'h00, 4'h1, 32'h19);
        check("os_cnt1", 32'(count8[7:0]), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("os_cnt3", 32'(count8[7:0]), 32'd3);
        check("os_irq_lag", 32'(irq8), 32'd0);
        @(posedge clk); #1;
        check("os_irq8", 32'(irq8), 32'd1);
        check("os_irq32", 32'(irq32), 32'd1);
        check("os_stopped", 32'(count8[7:0]), 32'd3);
        rd(8'h00);
        check("os_ctrl", r8, 32'h18);
        rd(8'h0C);
        check("os_status", r8, 32'h1);
        wr(8'h0C, 4'h1, 32'h1);
        check("os_irq_at_w1c", 32'(snap_irq8), 32'd1);
        check("os_irq_clr", 32'(irq8), 32'd0);
        wr(8'h00, 4'h1, 32'h0);

        // Partial byte write on CH2
        wr(8'h24, 4'hF, 32'h11223344);
        wr(8'h24, 4'b0100, 32'h00AA0000);
        rd(8'h24);
        check("pw_rd32", r32, 32'h11AA3344);
        check("pw_rd8", r8, 32'h44);
        check("pw_cnt", count32[95:64], 32'h11AA3344);

        // COUNT write while counting overrides the increment
        wr(8'h20, 4'h1, 32'h1);
        check("cw_run", count32[95:64], 32'h11AA3345);
        wr(8'h24, 4'hF, 32'h100);
        check("cw_written", snap32[95:64], 32'h100);
        check("cw_resume", count32[95:64], 32'h101);

        // Out-of-range channel
        wr(8'h50, 4'hF, 32'hFFFFFFFF);
        rd(8'h50);
        check("oor_rd32", r32, 32'h0);
        check("oor_rd8", r8, 32'h0);

        // Reset mid-count with a read pending
        reset = 1'b1; valid = 1'b1; addr = 8'h24; wstrb = 4'd0;
        @(posedge clk); #1;
        check("mrst_ready", 32'(ready32), 32'd0);
        check("mrst_count", 32'(|count32), 32'd0);
        check("mrst_rdata", rdata32, 32'd0);
        reset = 1'b0; valid = 1'b0;
        @(posedge clk); #1;
        check("mrst_noack", 32'(ready32), 32'd0);
        check("mrst_stay0", 32'(|count32), 32'd0);
        rd(8'h20);
        check("mrst_ctrl", r32, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_counter.md
Name: multi_channel_counter

Overview:
- Wishbone-mapped bank of CHANNELS independent BITS-wide counters for the user project area.
- Generalises the single-counter design with:
  - per-channel up/down direction
  - wrap or saturate mode
  - a compare register with sticky match/overflow status and a one-shot stop
  - an aggregated interrupt
- Counter values drive GPIO/LA through the top level; the top level derives valid and wstrb from cyc/stb/sel/we.

Parameters:
BITS, 32, counter and compare width per channel (1..32); register reads zero-extend to 32 bits
CHANNELS, 4, number of counters (1..16)

Ports:
clk  input  1  system clock (one clock domain)
reset  input  1  synchronous, active-high reset
valid  input  1  Wishbone cycle and strobe active
wstrb  input  4  byte write enables (sel & we); all zero = read
addr  input  8  byte address (wbs_adr_i[7:0]); [7:4] channel, [3:2] register
wdata  input  32  write data
rdata  output  32  read data, valid while ready=1
ready  output  1  Wishbone ack
count  output  CHANNELS*BITS  concatenated counter values, channel 0 in LSBs
irq  output  1  OR over channels of (MATCH & IRQ_EN), registered

Behaviour:
- Reset, synchronous on clk while reset=1:
  - All outputs are 0: ready, rdata, count, irq.
  - All CTRL, COUNT, CMP and STATUS registers clear to 0.
  - A transaction in flight is dropped; no ack is issued for it.
- Register map per channel, offset 0x00 + 16*ch:
  - 0x0 CTRL:
    - bit0 EN
    - bit1 DIR (0 up, 1 down)
    - bit2 SAT (0 wrap, 1 saturate)
    - bit3 IRQ_EN
    - bit4 ONESHOT
  - 0x4 COUNT
  - 0x8 CMP
  - 0xC STATUS:
    - bit0 MATCH, sticky
    - bit1 OVF, sticky
    - write-1-to-clear
- Handshake:
  - A transaction is accepted on a cycle with valid=1 and ready=0.
  - ready=1 on the next cycle for exactly one cycle, then 0.
  - Back-to-back transactions with valid held give ack every 2nd cycle.
  - Write data takes effect on the acceptance edge. Reads return the register value sampled at acceptance.
- Byte lanes:
  - Write is per byte per wstrb bit.
  - Bits at or above BITS are ignored on write and read as 0.
  - STATUS and CTRL use lane 0 only.
- Out-of-range channel (ch ≥ CHANNELS): reads return 0, writes are ignored, and ack is still issued.
- Counting, each cycle with EN=1 and no COUNT write to that channel:
  - Up: at 2^BITS-1, the next value is 0 (wrap) or stays at 2^BITS-1 (SAT). Either case sets OVF.
  - Down: at 0, the next value is 2^BITS-1 (wrap) or stays at 0 (SAT). Either case sets OVF.
  - Saturated hold re-asserts OVF every cycle (no additional effect).
- Match:
  - When the counted next value equals CMP, MATCH is set in the same edge.
  - If ONESHOT=1, EN clears in that edge.
  - A value written via COUNT equal to CMP does not set MATCH.
- Simultaneous events:
  - A bus COUNT write overrides the increment in that cycle.
  - When a STATUS W1C and a new set event occur in the same cycle, the set wins.
  - A CTRL write setting EN in the same cycle as a ONESHOT clear: the CTRL write wins.
- Timing:
  - count reflects the registers directly.
  - irq is updated one cycle after the MATCH/IRQ_EN change.

Test Plan:
- Reset then read CH0 COUNT (addr 0x04): ready pulses 1 cycle after valid; rdata=0; irq=0; count=0.
- CH1 (addr 0x10): CTRL=0x1, CMP=5, COUNT=0. After 5 enabled cycles COUNT=5 and STATUS (addr 0x1C) reads 0x1. Writing 0x1 to STATUS makes it read 0x0.
- BITS=8, CH0:
  - Up-wrap: COUNT=0xFE; after 2 cycles COUNT=0x00 and OVF=1.
  - Down-saturate: CTRL=0x7, COUNT=0x01; after 3 cycles COUNT holds 0x00 and OVF=1.
- ONESHOT+IRQ (CTRL=0x19, CMP=3) -> COUNT stops at 3, CTRL EN reads 0, irq rises 1 cycle after MATCH. irq clears 1 cycle after STATUS W1C.
- Partial write: COUNT=0x11223344 then wstrb=0b0100, wdata=0x00AA0000 -> COUNT=0x11AA3344. COUNT write during counting equals the written value on the next cycle, with no increment.
- Out-of-range (CHANNELS=4, addr 0x50) -> ready pulses and rdata=0. Reset asserted mid-count -> all registers 0 on the next edge and no ack.
